// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ADD/SUB/AND/OR/XOR/SLT and
// iterative unsigned MUL (shift-add) and DIVU (restoring), one bit per cycle.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start, op, a, c : request, operation select, operands (start ignored while busy)
//   out, rem        : registered result and remainder (rem nonzero only for DIVU)
//   zero, negative  : derived from the final out value
//   carry, overflow : carry/borrow/high-part flag, signed overflow / divide-by-zero
//   busy, done      : multi-cycle op in progress, one-cycle result-valid pulse
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIVU = 3'd7
  } op_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               fin;
  logic [WIDTH-1:0]   res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    acc_d   = acc_q;
    out_d   = out_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    res     = '0;

    add_w = {1'b0, a} + {1'b0, c};
    // Top bit of the extended difference is the unsigned borrow.
    sub_w = {1'b0, a} - {1'b0, c};

    // MUL: acc = {partial product, remaining multiplier bits}; add then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, c_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // DIV: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, c_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op_t'(op))
            OP_ADD: begin
              fin     = 1'b1;
              res     = add_w[WIDTH-1:0];
              carry_d = add_w[WIDTH];
              ovf_d   = (a[WIDTH-1] == c[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              fin     = 1'b1;
              res     = sub_w[WIDTH-1:0];
              carry_d = sub_w[WIDTH];
              ovf_d   = (a[WIDTH-1] != c[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND, OP_OR, OP_XOR, OP_SLT: begin
              fin     = 1'b1;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              if (op_t'(op) == OP_AND)      res = a & c;
              else if (op_t'(op) == OP_OR)  res = a | c;
              else if (op_t'(op) == OP_XOR) res = a ^ c;
              else                          res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(c))};
            end
            OP_MUL, OP_DIVU: begin
              c_d     = c;
              acc_d   = {{WIDTH{1'b0}}, a};
              cnt_d   = CNT_W'(WIDTH);
              busy_d  = 1'b1;
              state_d = (op_t'(op) == OP_MUL) ? ST_MUL : ST_DIV;
            end
            default: ;
          endcase
          if (fin) begin
            rem_d  = '0;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fin     = 1'b1;
          res     = mul_next[WIDTH-1:0];
          rem_d   = '0;
          carry_d = |mul_next[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // A zero divisor naturally yields all-ones quotient and remainder = a.
          fin     = 1'b1;
          res     = div_next[WIDTH-1:0];
          rem_d   = div_next[2*WIDTH-1:WIDTH];
          carry_d = 1'b0;
          ovf_d   = (c_q == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // zero/negative only follow a completed result so they stay 0 after reset.
    if (fin) begin
      out_d  = res;
      zero_d = (res == '0);
      neg_d  = res[WIDTH-1];
    end
  end

  assign out      = out_q;
  assign rem      = rem_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 2-bit-op combinational ALU.
- Adds XOR, signed SLT, an iterative unsigned multiply and an iterative unsigned divide, plus status flags and a start/busy/done handshake.
- Sits between the register file and the writeback mux in the CPU datapath.
- The control FSM stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (min 4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  3  operation select (table below)
a  in  WIDTH  operand A
c  in  WIDTH  operand C
out  out  WIDTH  registered result
rem  out  WIDTH  registered remainder (DIVU only, else 0)
zero  out  1  out == 0
negative  out  1  out[WIDTH-1]
carry  out  1  carry/borrow/high-part flag
overflow  out  1  signed overflow / divide-by-zero flag
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: result and flags valid

Behaviour:
- Reset (async, rst=1): out, rem, all flags, busy and done are forced to 0, counter cleared, FSM to IDLE. An active op is abandoned; no done is produced.
- op encoding:
  - 0 ADD: out = a+c; carry = carry-out; overflow = signed overflow.
  - 1 SUB: out = a-c; carry = borrow (a<c unsigned); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; carry = overflow = 0.
  - 5 SLT: out = 1 if signed a<c, else 0; carry = overflow = 0.
  - 6 MUL: out = low WIDTH bits of unsigned a*c; carry = 1 if high WIDTH bits nonzero; overflow = 0.
  - 7 DIVU: out = a/c, rem = a%c, carry = 0. If c=0: out = all ones, rem = a, overflow = 1.
- zero and negative are always derived from the final out value.
- rem = 0 for every op except 7.
- FSM states: IDLE, MUL, DIV.
- IDLE:
  - On an edge with start=1, ops 0-5 complete at that edge: out, rem and flags are registered, done=1 for the following cycle only, busy stays 0.
  - Ops 6/7 at that edge: latch a, c and op internally, clear the accumulator, load counter=WIDTH, set busy=1, and go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle using a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Multi-cycle completion: counter decrements every edge. On the edge where it reaches 0, out/rem/flags are registered, busy drops to 0, done pulses for one cycle, and the FSM returns to IDLE.
- Multi-cycle latency: start accepted at edge k → done high in cycle after edge k+WIDTH; busy high for exactly WIDTH cycles.
- Divide-by-zero still runs the full WIDTH iterations (constant latency).
- start while busy=1 is ignored; it is not queued.
- Changes on a/c/op during busy have no effect, because operands were latched at start.
- start in the cycle that done is high: accepted normally, enabling back-to-back ops.
- Between operations out and flags hold their last value; done=0.
- All arithmetic is modulo 2**WIDTH. Signed interpretation (SLT, overflow) is two's complement.

Test Plan:
- ADD wrap (WIDTH=32): a=FFFFFFFF, c=1, op=0, start pulse → next cycle out=0, zero=1, carry=1, overflow=0, done=1 for one cycle, busy=0.
- SUB underflow and SLT: a=0, c=1, op=1 → out=FFFFFFFF, negative=1, carry=1. Then a=FFFFFFFF, c=1, op=5 → out=1.
- Logic ops: a=F, c=3 with op=2/3/4 → out=3 / F / C; carry=overflow=0 each time.
- MUL: a=10000, c=10000, op=6 → busy high exactly 32 cycles, then out=0, carry=1, zero=1. Then a=7, c=6 → out=2A, carry=0. Toggling a/c and pulsing start mid-op does not change the result.
- DIVU: a=64, c=7, op=7 → out=E, rem=2 after 32 cycles. Then a=5, c=0 → out=FFFFFFFF, rem=5, overflow=1.
- Reset mid-MUL: assert rst at iteration 10 → all outputs 0 immediately (async), no done. After release, ADD 2+3 → out=5 with normal single-cycle latency.
